// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage; one quotient bit per cycle.
// Optional feature: define DIV_EARLY_OUT_EN to finish immediately when |dividend| < |divisor|.
module div_iter_unit #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               neg1, neg2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo_nxt, rem_nxt;

  // Operand magnitudes and sign flags, taken straight from the ports in IDLE
  always_comb begin
    neg1 = signed_div_i & opdata1_i[WIDTH-1];
    neg2 = signed_div_i & opdata2_i[WIDTH-1];
    mag1 = neg1 ? -opdata1_i : opdata1_i;
    mag2 = neg2 ? -opdata2_i : opdata2_i;
  end

  // One restoring step: quotient bit is the inverted borrow of the trial subtract
  always_comb begin
    trial   = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
    quo_nxt = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
    rem_nxt = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      S_IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          dvd_d     = mag1;
          dvs_d     = mag2;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = neg1 ^ neg2;
          neg_rem_d = neg1;
          if (opdata2_i == '0) begin
            state_d = S_DIVZERO;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (mag1 < mag2) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = {opdata1_i, WIDTH'(0)};
          end
`endif
          else begin
            state_d = S_ON;
          end
        end
      end
      S_DIVZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nxt;
          dvd_d = quo_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = {(neg_rem_q ? -rem_nxt : rem_nxt), (neg_quo_q ? -quo_nxt : quo_nxt)};
          end
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit (WIDTH=32); honours DIV_EARLY_OUT_EN for expected latency.
module tb_div_iter_unit;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  div_iter_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference via magnitudes and the simulator's unsigned / and %
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    logic na, nb;
    if (b == 32'd0) return 64'd0;
    na = s & a[31];
    nb = s & b[31];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (na ^ nb) q = -q;
    if (na) r = -r;
    return {r, q};
  endfunction

  function automatic int lat_of(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (s & a[31]) ? -a : a;
    mb = (s & b[31]) ? -b : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return W + 1;
  endfunction

  task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_r, input int exp_lat);
    int cyc;
    logic [63:0] e;
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(exp_r);
    tick();
    cyc = 1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~s;
    while (!ready_o && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'd0;
    chk({tag, " result"}, result_o, e);
    tick();
    chk({tag, " hold ready"}, 64'(ready_o), 64'd1);
    chk({tag, " hold result"}, result_o, e);
    start_i = 1'b0;
    tick();
    chk({tag, " idle ready"}, 64'(ready_o), 64'd0);
    chk({tag, " idle result"}, result_o, 64'd0);
    chk({tag, " idle busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("reset result", result_o, 64'd0);
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    tick();

    do_div("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, lat_of(1'b0, 32'd100, 32'd7));
    do_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
           lat_of(1'b1, 32'hFFFF_FFF9, 32'h2));
    do_div("u-7/2", 1'b0, 32'hFFFF_FFF9, 32'h2, {32'h1, 32'h7FFF_FFFC},
           lat_of(1'b0, 32'hFFFF_FFF9, 32'h2));
    do_div("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000},
           lat_of(1'b1, 32'h8000_0000, 32'hFFFF_FFFF));
    do_div("div0", 1'b0, 32'd1234, 32'd0, 64'd0, 2);
    do_div("u5/9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, lat_of(1'b0, 32'd5, 32'd9));
    do_div("u9/5", 1'b0, 32'd9, 32'd5, {32'd4, 32'd1}, W + 1);
    do_div("s-3/9", 1'b1, 32'hFFFF_FFFD, 32'd9, {32'hFFFF_FFFD, 32'd0},
           lat_of(1'b1, 32'hFFFF_FFFD, 32'd9));

    // Annul mid-division, then a clean restart
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    tick();
    repeat (9) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    chk("annul busy", 64'(busy_o), 64'd0);
    chk("annul ready", 64'(ready_o), 64'd0);
    annul_i = 1'b0;
    do_div("u9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, W + 1);

    // Annul while holding a ready result, with start still high
    opdata1_i = 32'd3;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    tick();
    tick();
    chk("end ready", 64'(ready_o), 64'd1);
    annul_i = 1'b1;
    tick();
    chk("end annul ready", 64'(ready_o), 64'd0);
    chk("end annul result", result_o, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();

    // Synchronous reset mid-division
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    tick();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rst result", result_o, 64'd0);
    chk("rst ready", 64'(ready_o), 64'd0);
    chk("rst busy", 64'(busy_o), 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      do_div($sformatf("rnd%0d", i), s, a, b, model(s, a, b), lat_of(s, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
